// File: rtl/cpu_core.sv
// Single-cycle RV32I integer-ALU core: register file plus registered zero flag.
// Optional macro RESULT_OUT_EN adds a registered `result` output of the last ALU result.
module cpu_core #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     in,
`ifdef RESULT_OUT_EN
  output logic [XLEN-1:0] result,
`endif
  output logic            zero
);

  localparam int unsigned RW = 5;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] F7_0   = 7'b0000000;
  localparam logic [6:0] F7_ALT = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND, ALU_LUI
  } alu_op_e;

  logic [XLEN-1:0] r_regs [NREGS];
  logic            r_zero;

  logic [6:0]      w_opcode;
  logic [6:0]      w_f7;
  logic [2:0]      w_f3;
  logic [RW-1:0]   w_rd;
  logic [RW-1:0]   w_rs1;
  logic [RW-1:0]   w_rs2;
  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_op2;
  logic [RW-1:0]   w_shamt;
  logic            w_valid;
  alu_op_e         w_op;
  logic [XLEN-1:0] w_res;

  assign w_opcode = in[6:0];
  assign w_rd     = in[11:7];
  assign w_f3     = in[14:12];
  assign w_rs1    = in[19:15];
  assign w_rs2    = in[24:20];
  assign w_f7     = in[31:25];
  assign w_imm    = {{(XLEN-12){in[31]}}, in[31:20]};

  // x0 reads as zero regardless of storage contents
  assign w_a = (w_rs1 == '0) ? '0 : r_regs[w_rs1];
  assign w_b = (w_rs2 == '0) ? '0 : r_regs[w_rs2];

  // Decode: select operation and second operand, flag illegal encodings
  always_comb begin
    w_valid = 1'b0;
    w_op    = ALU_ADD;
    w_op2   = w_b;
    w_shamt = w_b[RW-1:0];
    unique case (w_opcode)
      OP_R: begin
        if (w_f7 == F7_0) begin
          w_valid = 1'b1;
          unique case (w_f3)
            3'b000: w_op = ALU_ADD;
            3'b001: w_op = ALU_SLL;
            3'b010: w_op = ALU_SLT;
            3'b011: w_op = ALU_SLTU;
            3'b100: w_op = ALU_XOR;
            3'b101: w_op = ALU_SRL;
            3'b110: w_op = ALU_OR;
            default: w_op = ALU_AND;
          endcase
        end else if (w_f7 == F7_ALT && w_f3 == 3'b000) begin
          w_valid = 1'b1;
          w_op    = ALU_SUB;
        end else if (w_f7 == F7_ALT && w_f3 == 3'b101) begin
          w_valid = 1'b1;
          w_op    = ALU_SRA;
        end
      end
      OP_I: begin
        w_op2   = w_imm;
        w_shamt = in[24:20];
        unique case (w_f3)
          3'b000: begin w_valid = 1'b1; w_op = ALU_ADD;  end
          3'b010: begin w_valid = 1'b1; w_op = ALU_SLT;  end
          3'b011: begin w_valid = 1'b1; w_op = ALU_SLTU; end
          3'b100: begin w_valid = 1'b1; w_op = ALU_XOR;  end
          3'b110: begin w_valid = 1'b1; w_op = ALU_OR;   end
          3'b111: begin w_valid = 1'b1; w_op = ALU_AND;  end
          3'b001: begin w_valid = (w_f7 == F7_0); w_op = ALU_SLL; end
          default: begin
            w_valid = (w_f7 == F7_0) || (w_f7 == F7_ALT);
            w_op    = (w_f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
          end
        endcase
      end
      OP_LUI: begin
        w_valid = 1'b1;
        w_op    = ALU_LUI;
      end
      default: w_valid = 1'b0;
    endcase
  end

  // ALU: arithmetic wraps, shifts use the low five bits
  always_comb begin
    w_res = '0;
    unique case (w_op)
      ALU_ADD:  w_res = w_a + w_op2;
      ALU_SUB:  w_res = w_a - w_op2;
      ALU_SLL:  w_res = w_a << w_shamt;
      ALU_SLT:  w_res = XLEN'($signed(w_a) < $signed(w_op2));
      ALU_SLTU: w_res = XLEN'(w_a < w_op2);
      ALU_XOR:  w_res = w_a ^ w_op2;
      ALU_SRL:  w_res = w_a >> w_shamt;
      ALU_SRA:  w_res = XLEN'($signed(w_a) >>> w_shamt);
      ALU_OR:   w_res = w_a | w_op2;
      ALU_AND:  w_res = w_a & w_op2;
      default:  w_res = {in[31:12], 12'b0};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_zero <= 1'b0;
    end else if (w_valid) begin
      if (w_rd != '0) r_regs[w_rd] <= w_res;
      r_zero <= (w_res == '0);
    end
  end

  assign zero = r_zero;

`ifdef RESULT_OUT_EN
  logic [XLEN-1:0] r_result;

  always_ff @(posedge clk) begin
    if (rst)          r_result <= '0;
    else if (w_valid) r_result <= w_res;
  end

  assign result = r_result;
`endif

endmodule

// File: tb/tb_cpu_core.sv
// Directed-vector bench for cpu_core: zero flag and register file contents checked
// against hand-computed values after each executed instruction.
module tb_cpu_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in;
  logic        zero;
`ifdef RESULT_OUT_EN
  logic [31:0] result;
`endif

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  cpu_core dut (
    .clk    (clk),
    .rst    (rst),
    .in     (in),
`ifdef RESULT_OUT_EN
    .result (result),
`endif
    .zero   (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present one word, let it execute on the next rising edge, settle before sampling
  task automatic exec(input logic [31:0] word);
    in = word;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    in  = 32'h0010_0793;          // addi x15,x0,1 -- must be ignored under reset
    @(posedge clk);
    #1;
    check("rst_zero", 32'(zero), 32'd0);
    check("rst_x30", dut.r_regs[30], 32'd0);
    check("rst_x15", dut.r_regs[15], 32'd0);

    rst = 1'b0;
    exec(32'h0020_81B3);          // add x3,x1,x2
    check("add0_zero", 32'(zero), 32'd1);
    check("add0_x3", dut.r_regs[3], 32'd0);

    exec(32'h0630_0F13);          // addi x30,x0,99
    check("addi99_zero", 32'(zero), 32'd0);
    check("addi99_x30", dut.r_regs[30], 32'h63);

    exec(32'h0108_03B3);          // add x7,x16,x16
    check("add16_zero", 32'(zero), 32'd1);
    check("add16_x7", dut.r_regs[7], 32'd0);

    exec(32'h0050_0093);          // addi x1,x0,5
    check("addi5_zero", 32'(zero), 32'd0);
    exec(32'h0050_0113);          // addi x2,x0,5
    check("addi5_x1", dut.r_regs[1], 32'd5);
    exec(32'h4020_81B3);          // sub x3,x1,x2
    check("sub_zero", 32'(zero), 32'd1);
    check("sub_x3", dut.r_regs[3], 32'd0);
    exec(32'h0011_2233);          // slt x4,x2,x1
    check("slt_x4", dut.r_regs[4], 32'd0);
    check("slt_zero", 32'(zero), 32'd1);

    exec(32'hFFF0_0293);          // addi x5,x0,-1
    check("neg1_x5", dut.r_regs[5], 32'hFFFF_FFFF);
    check("neg1_zero", 32'(zero), 32'd0);
    exec(32'h01F2_D313);          // srli x6,x5,31
    check("srli_x6", dut.r_regs[6], 32'd1);
    exec(32'h41F2_D313);          // srai x6,x5,31
    check("srai_x6", dut.r_regs[6], 32'hFFFF_FFFF);

    exec(32'h0050_B433);          // sltu x8,x1,x5
    check("sltu_x8", dut.r_regs[8], 32'd1);
    exec(32'h0012_A4B3);          // slt x9,x5,x1
    check("slt_neg_x9", dut.r_regs[9], 32'd1);
    exec(32'h1234_5537);          // lui x10,0x12345
    check("lui_x10", dut.r_regs[10], 32'h1234_5000);
    exec(32'h00A2_F5B3);          // and x11,x5,x10
    check("and_x11", dut.r_regs[11], 32'h1234_5000);
    exec(32'hFFF5_4613);          // xori x12,x10,-1
    check("xori_x12", dut.r_regs[12], 32'hEDCB_AFFF);
    exec(32'h0012_86B3);          // add x13,x5,x1 (wraps)
    check("wrap_x13", dut.r_regs[13], 32'd4);
    exec(32'h00C0_9733);          // sll x14,x1,x12 (shamt = 31 from low bits)
    check("sll_x14", dut.r_regs[14], 32'h8000_0000);
`ifdef RESULT_OUT_EN
    check("sll_result", result, 32'h8000_0000);
`endif

    exec(32'h4020_81B3);          // sub x3,x1,x2 -> zero=1
    exec(32'h0220_8333);          // funct7=0000001: illegal, zero and x6 hold
    check("ill_r_zero", 32'(zero), 32'd1);
    check("ill_r_x6", dut.r_regs[6], 32'hFFFF_FFFF);

    exec(32'h0070_0013);          // addi x0,x0,7
    check("x0w_zero", 32'(zero), 32'd0);
    check("x0w_x0", dut.r_regs[0], 32'd0);
    exec(32'hFFFF_FFFF);          // illegal opcode
    check("ill_zero", 32'(zero), 32'd0);
    check("ill_x31", dut.r_regs[31], 32'd0);
    check("ill_x30", dut.r_regs[30], 32'h63);

    rst = 1'b1;
    exec(32'h0050_0093);          // addi x1,x0,5 under reset: not executed
    check("rst2_zero", 32'(zero), 32'd0);
    check("rst2_x30", dut.r_regs[30], 32'd0);
    check("rst2_x1", dut.r_regs[1], 32'd0);
`ifdef RESULT_OUT_EN
    check("rst2_result", result, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
